// File: rtl/morty_pkg.sv
// morty_pkg: shared encodings, constants and types for the morty fetch stage
package morty_pkg;
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_EXC    = 2'b11
  } pc_sel_e;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_DRAIN, ST_HOLD} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
    logic        fault;
  } fetch_entry_t;
endpackage

// File: rtl/morty_fetch_stage_if.sv
// morty_fetch_stage_if: instruction bus between the fetch stage (master) and memory (slave)
//   addr/cyc/stb: request from master; dat/ack/err: response from slave
interface morty_fetch_stage_if;
  logic [31:0] addr;
  logic [31:0] dat;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  modport master(output addr, cyc, stb, input dat, ack, err);
  modport slave(input addr, cyc, stb, output dat, ack, err);
endinterface

// File: rtl/morty_fetch_buffer.sv
// morty_fetch_buffer: single-entry holding register for a fetch result parked during a stall
//   clk, rst (sync, active-high), load/d: capture an entry, clr: drop it, valid/q: stored entry
module morty_fetch_buffer
  import morty_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  fetch_entry_t d,
  output logic         valid,
  output fetch_entry_t q
);
  always_ff @(posedge clk)
    if (rst || clr) valid <= 1'b0;
    else if (load) valid <= 1'b1;
  always_ff @(posedge clk)
    if (load) q <= d;
endmodule

// File: rtl/morty_fetch_stage.sv
// morty_fetch_stage: instruction fetch with redirect drain, stall hold buffer and IF/ID register
//   clk_i, rst_i (sync, active-low); if_pc_sel_i + branch/jump/exception targets select the next PC;
//   if_stall_i/if_kill_i/if_bubble_i pipeline control; iport instruction bus master;
//   if_stall_req_o fetch incomplete; pc_o/instruction_o/opcode_o/func3_o/func7_o/valid_o/fetch_fault_o IF/ID
module morty_fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = morty_pkg::NOP_INST
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          if_pc_sel_i,
  input  logic [31:0]         branch_target_i,
  input  logic [31:0]         jump_target_i,
  input  logic [31:0]         exception_pc_i,
  input  logic                if_stall_i,
  input  logic                if_kill_i,
  input  logic                if_bubble_i,
  morty_fetch_stage_if.master iport,
  output logic                if_stall_req_o,
  output logic [31:0]         pc_o,
  output logic [31:0]         instruction_o,
  output logic [6:0]          opcode_o,
  output logic [2:0]          func3_o,
  output logic [6:0]          func7_o,
  output logic                valid_o,
  output logic                fetch_fault_o
);
  import morty_pkg::*;
  fetch_state_e state, state_n;
  fetch_entry_t fresh, held;
  logic [31:0] pc_q, drain_addr, target;
  logic redirect, req, cyc, resp, fault, got, go_hold, held_valid, take_held;
  assign redirect = if_pc_sel_i != PC_SEQ;
  assign target = if_pc_sel_i == PC_BRANCH ? branch_target_i :
                  if_pc_sel_i == PC_JUMP   ? jump_target_i : exception_pc_i;
  // a misaligned PC never reaches the bus; it completes at once as a fault
  assign req = state == ST_FETCH && pc_q[1:0] == 2'b00;
  assign cyc = req || state == ST_DRAIN;
  assign iport.cyc = cyc;
  assign iport.stb = cyc;
  assign iport.addr = state == ST_DRAIN ? drain_addr : pc_q;
  assign resp = state == ST_FETCH && (!req || iport.ack || iport.err);
  assign fault = !req || iport.err;
  assign got = resp && !redirect;
  assign go_hold = got && if_stall_i && !if_kill_i;
  assign take_held = held_valid && !redirect && !if_kill_i && !if_stall_i && !if_bubble_i;
  assign fresh = {pc_q, fault ? NOP_INST : iport.dat, fault};
  assign if_stall_req_o = state == ST_RESET ||
                          ((state == ST_FETCH || state == ST_DRAIN) && !iport.ack && !iport.err);
  morty_fetch_buffer u_buf (
    .clk  (clk_i),
    .rst  (!rst_i),
    .load (go_hold),
    .clr  (redirect || if_kill_i || take_held),
    .d    (fresh),
    .valid(held_valid),
    .q    (held)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_RESET: state_n = ST_FETCH;
      ST_FETCH: state_n = go_hold ? ST_HOLD : (redirect && !resp) ? ST_DRAIN : ST_FETCH;
      ST_DRAIN: state_n = (iport.ack || iport.err) ? ST_FETCH : ST_DRAIN;
      ST_HOLD:  state_n = (redirect || if_kill_i || take_held) ? ST_FETCH : ST_HOLD;
      default:  state_n = ST_RESET;
    endcase
  end
  always_ff @(posedge clk_i)
    if (!rst_i) state <= ST_RESET;
    else state <= state_n;
  always_ff @(posedge clk_i)
    if (!rst_i) pc_q <= RESET_ADDR;
    else if (redirect) pc_q <= target;
    else if (req && iport.ack && !iport.err) pc_q <= pc_q + 32'd4;
  // the abandoned request keeps its address on the bus while pc_q already holds the target
  always_ff @(posedge clk_i)
    if (!rst_i) drain_addr <= RESET_ADDR;
    else if (state == ST_FETCH && redirect && !resp) drain_addr <= pc_q;
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      pc_o          <= RESET_ADDR;
      instruction_o <= NOP_INST;
      valid_o       <= 1'b0;
      fetch_fault_o <= 1'b0;
    end else if (if_bubble_i || if_kill_i) begin
      instruction_o <= NOP_INST;
      valid_o       <= 1'b0;
      fetch_fault_o <= 1'b0;
    end else if (!if_stall_i) begin
      if (take_held || got) begin
        {pc_o, instruction_o, fetch_fault_o} <= take_held ? held : fresh;
        valid_o <= 1'b1;
      end else begin
        instruction_o <= NOP_INST;
        valid_o       <= 1'b0;
        fetch_fault_o <= 1'b0;
      end
    end
  assign opcode_o = instruction_o[6:0];
  assign func3_o  = instruction_o[14:12];
  assign func7_o  = instruction_o[31:25];
endmodule

// File: tb/tb_morty_fetch_stage.sv
// tb_morty_fetch_stage: randomized and directed stimulus against a transaction-level fetch model
module tb_morty_fetch_stage;
  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst_i;
  logic [1:0] if_pc_sel_i;
  logic [31:0] branch_target_i, jump_target_i, exception_pc_i;
  logic if_stall_i, if_kill_i, if_bubble_i, if_stall_req_o, valid_o, fetch_fault_o;
  logic [31:0] pc_o, instruction_o;
  logic [6:0] opcode_o, func7_o;
  logic [2:0] func3_o;
  int n_vec = 0;
  int n_bad = 0;
  morty_fetch_stage_if iport();
  morty_fetch_stage dut (
    .clk_i(clk), .rst_i(rst_i), .if_pc_sel_i(if_pc_sel_i),
    .branch_target_i(branch_target_i), .jump_target_i(jump_target_i), .exception_pc_i(exception_pc_i),
    .if_stall_i(if_stall_i), .if_kill_i(if_kill_i), .if_bubble_i(if_bubble_i),
    .iport(iport.master), .if_stall_req_o(if_stall_req_o),
    .pc_o(pc_o), .instruction_o(instruction_o), .opcode_o(opcode_o), .func3_o(func3_o),
    .func7_o(func7_o), .valid_o(valid_o), .fetch_fault_o(fetch_fault_o)
  );
  always #5 clk = ~clk;
  // model: next address to fetch, a wrong-path request still owed a response, parked results, IF/ID contents
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic fault;} ent_t;
  ent_t parked[$];
  logic [31:0] m_pc, stale_addr, e_pc, e_inst;
  logic started, stale, e_valid, e_fault;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic [1:0] sel, input logic [31:0] tg,
                      input logic st, input logic ki, input logic bu, input int ack_pct, input int err_pct);
    logic x_cyc, x_sreq, ak, er, aligned, resp, have_dl;
    logic [31:0] x_addr, d;
    ent_t en, dl;
    rst_i = r; if_pc_sel_i = sel; if_stall_i = st; if_kill_i = ki; if_bubble_i = bu;
    branch_target_i = $urandom; jump_target_i = $urandom; exception_pc_i = $urandom;
    case (sel)
      2'b01: branch_target_i = tg;
      2'b10: jump_target_i = tg;
      2'b11: exception_pc_i = tg;
      default: ;
    endcase
    aligned = m_pc[1:0] == 2'b00;
    x_cyc = started && (stale || (parked.size() == 0 && aligned));
    x_addr = stale ? stale_addr : m_pc;
    er = x_cyc && ($urandom_range(99) < err_pct);
    ak = x_cyc && !er && ($urandom_range(99) < ack_pct);
    if (!started && $urandom_range(3) == 0) ak = 1'b1;
    d = $urandom;
    iport.ack = ak; iport.err = er; iport.dat = d;
    x_sreq = !started || ((stale || parked.size() == 0) && !ak && !er);
    @(negedge clk);
    chk("cyc", 32'(iport.cyc), 32'(x_cyc));
    chk("stb", 32'(iport.stb), 32'(x_cyc));
    if (x_cyc || !started) chk("addr", iport.addr, x_addr);
    chk("stall_req", 32'(if_stall_req_o), 32'(x_sreq));
    chk("pc", pc_o, e_pc);
    chk("inst", instruction_o, e_inst);
    chk("valid", 32'(valid_o), 32'(e_valid));
    chk("fault", 32'(fetch_fault_o), 32'(e_fault));
    chk("opcode", 32'(opcode_o), 32'(e_inst[6:0]));
    chk("func3", 32'(func3_o), 32'(e_inst[14:12]));
    chk("func7", 32'(func7_o), 32'(e_inst[31:25]));
    @(posedge clk);
    have_dl = 1'b0;
    dl = '{RST_A, NOP, 1'b0};
    if (!r) begin
      m_pc = RST_A; started = 1'b0; stale = 1'b0; parked.delete();
      e_pc = RST_A; e_inst = NOP; e_valid = 1'b0; e_fault = 1'b0;
    end else begin
      if (!started) started = 1'b1;
      else if (stale) begin
        if (ak || er) stale = 1'b0;
      end else if (parked.size() != 0) begin
        if (sel != 2'b00 || ki) parked.delete();
        else if (!st && !bu) begin dl = parked.pop_front(); have_dl = 1'b1; end
      end else begin
        resp = !aligned || ak || er;
        if (resp && sel == 2'b00) begin
          en = '{m_pc, (aligned && !er) ? d : NOP, !aligned || er};
          if (aligned && ak && !er) m_pc = m_pc + 32'd4;
          if (st && !ki) parked.push_back(en);
          else begin dl = en; have_dl = 1'b1; end
        end else if (!resp && sel != 2'b00) begin
          stale = 1'b1; stale_addr = m_pc;
        end
      end
      if (sel != 2'b00) m_pc = tg;
      if (bu || ki) begin e_inst = NOP; e_valid = 1'b0; e_fault = 1'b0; end
      else if (!st) begin
        if (have_dl) begin e_pc = dl.pc; e_inst = dl.inst; e_valid = 1'b1; e_fault = dl.fault; end
        else begin e_inst = NOP; e_valid = 1'b0; e_fault = 1'b0; end
      end
    end
    #1;
  endtask
  initial begin
    logic [1:0] sel;
    logic [31:0] tg;
    int k;
    rst_i = 1'b0; if_pc_sel_i = 2'b00; if_stall_i = 1'b0; if_kill_i = 1'b0; if_bubble_i = 1'b0;
    branch_target_i = '0; jump_target_i = '0; exception_pc_i = '0;
    iport.ack = 1'b0; iport.err = 1'b0; iport.dat = '0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = RST_A; started = 1'b0; stale = 1'b0; stale_addr = RST_A;
    e_pc = RST_A; e_inst = NOP; e_valid = 1'b0; e_fault = 1'b0;
    repeat (2) step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (6) step(1'b1, 2'b00, 0, 0, 0, 0, 100, 0);
    repeat (3) step(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) step(1'b1, 2'b00, 0, 0, 0, 0, 100, 0);
    step(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    step(1'b1, 2'b10, 32'h100, 0, 0, 0, 0, 0);
    step(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1'b1, 2'b00, 0, 0, 0, 0, 100, 0);
    step(1'b1, 2'b00, 0, 1, 0, 0, 100, 0);
    step(1'b1, 2'b00, 0, 1, 0, 0, 100, 0);
    repeat (3) step(1'b1, 2'b00, 0, 0, 0, 0, 100, 0);
    step(1'b1, 2'b10, 32'h40, 0, 0, 0, 0, 0);
    step(1'b1, 2'b00, 0, 0, 0, 0, 0, 100);
    step(1'b1, 2'b01, 32'h42, 0, 0, 0, 0, 0);
    repeat (2) step(1'b1, 2'b00, 0, 0, 0, 0, 100, 0);
    step(1'b1, 2'b10, 32'h200, 0, 0, 0, 0, 0);
    step(1'b1, 2'b00, 0, 0, 1, 0, 100, 0);
    repeat (2) step(1'b1, 2'b00, 0, 0, 0, 0, 100, 0);
    step(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) step(1'b0, 2'b00, 0, 0, 0, 0, 100, 0);
    step(1'b1, 2'b10, 32'hFFFF_FFF8, 0, 0, 0, 100, 0);
    repeat (5) step(1'b1, 2'b00, 0, 0, 0, 0, 100, 0);
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(7);
      tg = k == 0 ? 32'h100 : k == 1 ? 32'hFFFF_FFF8 :
           k == 2 ? (($urandom & 32'h0000_0FFC) | 32'($urandom_range(3, 1))) : ($urandom & 32'h0000_0FFC);
      sel = $urandom_range(99) < 85 ? 2'b00 : 2'($urandom_range(3, 1));
      k = $urandom_range(2);
      step($urandom_range(99) >= 2, sel, tg, $urandom_range(99) < 25, $urandom_range(99) < 5,
           $urandom_range(99) < 5, k == 0 ? 100 : k == 1 ? 50 : 20, 5);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
